uart_transmitter: RTL and testbench
===================================

# uart_transmitter

Serial UART transmitter: the sending end of the link whose receiver samples `uart_rx` with an 18-clock bit period, LSB-first data, even parity and two stop bits. Accepts bytes over a valid/ready handshake into a one-entry holding register. Serialises each byte as start, 8 data, parity and stop bits on a registered `uart_tx` line. Sits between the CPU's memory-mapped I/O write path and the board TX pin.

## Interface
Parameters:
- `CLOCKS_PER_BIT`, default 18: clock cycles per serial bit; must be ≥2 and must match the receiver.
- `STOP_BITS`, default 2: number of stop bits, 1 or 2.

Ports:
- `clock`  in  1: sole clock; all state updates on the rising edge.
- `clear`  in  1: reset, synchronous, active-high.
- `data_in_valid`  in  1: byte offered on `data_in`.
- `data_in`  in  8: byte to transmit.
- `data_in_ready`  out  1: block can accept a byte this cycle.
- `uart_tx`  out  1: serial line, idle high.
- `busy`  out  1: a frame is in progress (state ≠ IDLE).

## Operation
- **Accept:** a byte is accepted when `data_in_valid & data_in_ready`. `data_in_ready = ~holding_full`, a registered flag.
- **Direct load:** if the FSM is in IDLE, or is in the final cycle of the last stop bit, an accepted byte loads directly into the shift register. Otherwise it goes to the holding register and sets `holding_full`.
- **FSM states:** IDLE → START → DATA → PARITY → STOP → IDLE/START.
  - IDLE: `uart_tx`=1. Leave on a direct load or when `holding_full`; the holding byte moves to the shift register and `holding_full` clears.
  - START: `uart_tx`=0 for one bit period.
  - DATA: 8 bit periods. Bit index 0..7, LSB first, `uart_tx = shift[index]`. Index increments on each bit-timer tick. Leave after index 7.
  - PARITY: `uart_tx` = XOR of the 8 data bits (even parity across data + parity), one bit period.
  - STOP: `uart_tx`=1 for `STOP_BITS` periods. On the last tick:
    - if `holding_full`, go straight to START with no idle gap;
    - else if an accept occurs in that same cycle, go to START with the new byte;
    - else go to IDLE.
- **Bit timer:** counts 0..`CLOCKS_PER_BIT`-1, width `$clog2(CLOCKS_PER_BIT)`. Tick when count = `CLOCKS_PER_BIT`-1, then wrap to 0. Forced to 0 on every frame start, so the start bit is always full length.
- **Parity:** accumulated as a running XOR during DATA, or computed from the shift register at load. Either is acceptable; the output value is what counts.
- **`clear` mid-frame:** the frame is abandoned. `uart_tx`=1 on the next cycle, the holding byte is discarded, and no partial byte resumes.

## Timing
- Reset values:
  - `uart_tx`=1, `data_in_ready`=1, `busy`=0.
  - State IDLE, `holding_full`=0, bit timer 0.
- `uart_tx` and `busy` are registered.
- Accept in IDLE at cycle N: `uart_tx` falls at N+1, `busy`=1 at N+1.
- Each bit is held exactly `CLOCKS_PER_BIT` cycles.
- Frame length:
  - (1+8+1+`STOP_BITS`)·`CLOCKS_PER_BIT` cycles; 216 at the defaults.
  - (1+8+`STOP_BITS`)·`CLOCKS_PER_BIT` without parity.
- Back-to-back bytes: the next start bit begins the cycle after the last stop-bit cycle, so there is zero idle time.
- `data_in_ready`:
  - falls the cycle after a byte enters the holding register;
  - rises the cycle after the holding byte is moved to the shift register.
- Holding empty and FSM busy: an accept is stored and never lost. With holding full, `data_in_valid` is ignored.

## Configuration
- `UART_TRANSMITTER_PARITY_EN`:
  - **Defined:** the PARITY state is present and frames carry the even-parity bit. This is the normal build; it matches the receiver.
  - **Undefined:** the PARITY state and parity logic are removed, DATA goes directly to STOP, and the frame is one bit period shorter.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - `UART_DATA_BITS`=8;
  - default constants `UART_CLOCKS_PER_BIT`=18 and `UART_STOP_BITS`=2, shared with the receiver.
- Sub-module `uart_bit_timer`, parameterised by `CLOCKS_PER_BIT`:
  - inputs `clock`, `clear`, `restart`;
  - output `tick`.
- Top level holds the FSM, shift register, holding register, parity and output register.

## Test plan
All scenarios use `CLOCKS_PER_BIT`=4, `STOP_BITS`=2 unless noted.
- **Reset:** hold `clear` 3 cycles → `uart_tx`=1, `data_in_ready`=1, `busy`=0 throughout.
- **Single byte:** send 0xA5 from IDLE.
  - `uart_tx` over 48 cycles, 4 cycles per bit: 0, 1,0,1,0,0,1,0,1, 0 (parity), 1,1.
  - `busy` high for exactly 48 cycles.
- **Parity of 0x07:** data bits 1,1,1,0,0,0,0,0 → parity bit = 1.
- **Back-to-back:** send 0x01, then 0x80 one cycle later.
  - `data_in_ready` drops.
  - The 0x80 start bit begins immediately after the second stop bit of 0x01, with no idle cycle.
  - `data_in_ready` returns high on the following cycle.
- **Clear mid-frame:** assert `clear` at cycle 20 of a 0x3C frame (in DATA) with a byte held.
  - `uart_tx`=1 next cycle and the held byte is dropped.
  - A subsequent 0x55 transmits a complete, correct frame.
- **Macro undefined, `CLOCKS_PER_BIT`=18:** send 0xFF → frame 0, eight 1s, 1,1 over 198 cycles, with no parity bit.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions. Holds the transmitter FSM state
//                encoding, the data width, and the default line constants
//                that the matching receiver also uses.
//  Contents    : uart_state_t, UART_DATA_BITS, UART_CLOCKS_PER_BIT,
//                UART_STOP_BITS
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int UART_DATA_BITS      = 8;
  localparam int UART_CLOCKS_PER_BIT = 18;
  localparam int UART_STOP_BITS      = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_bit_timer
//  Description : Free-running bit-period counter. Counts 0..CLOCKS_PER_BIT-1
//                and pulses tick on the last count of every bit period.
//  Ports       : clock   - rising-edge clock
//                clear   - synchronous active-high reset
//                restart - forces the count to 0 (frame start)
//                tick    - high during the final cycle of a bit period
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_timer #(
  parameter int CLOCKS_PER_BIT = 18
) (
  input  logic clock,
  input  logic clear,
  input  logic restart,
  output logic tick
);

  localparam int             c_W    = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [c_W-1:0] c_LAST = c_W'(CLOCKS_PER_BIT - 1);

  logic [c_W-1:0] r_count;

  assign tick = (r_count == c_LAST);

  always_ff @(posedge clock) begin
    if (clear || restart) begin
      r_count <= '0;
    end else if (tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule : uart_bit_timer
`default_nettype wire

// File: rtl/uart_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_transmitter
//  Description : UART transmitter with valid/ready byte input and a one-entry
//                holding register. Sends start, 8 data bits (LSB first),
//                optional even parity and STOP_BITS stop bits on a registered
//                serial line. Back-to-back bytes leave no idle gap.
//  Config      : UART_TRANSMITTER_PARITY_EN - when defined, frames carry the
//                even-parity bit; when undefined the PARITY state is removed.
//  Ports       : clock         - rising-edge clock
//                clear         - synchronous active-high reset
//                data_in_valid - byte offered on data_in
//                data_in       - byte to transmit
//                data_in_ready - holding register empty, byte can be taken
//                uart_tx       - serial line, idle high
//                busy          - frame in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = UART_CLOCKS_PER_BIT,
  parameter int STOP_BITS      = UART_STOP_BITS
) (
  input  logic                      clock,
  input  logic                      clear,
  input  logic                      data_in_valid,
  input  logic [UART_DATA_BITS-1:0] data_in,
  output logic                      data_in_ready,
  output logic                      uart_tx,
  output logic                      busy
);

  // Stop-bit counter only needs to distinguish the first and second stop bit.
  localparam logic [0:0] c_STOP_LAST = 1'(STOP_BITS - 1);

  uart_state_t               r_state;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] r_holding;
  logic                      r_holding_full;
  logic [2:0]                r_index;
  logic [0:0]                r_stop_cnt;
  logic                      r_tx;
  logic                      r_busy;

  logic w_tick;
  logic w_accept;
  logic w_last_stop;
  logic w_direct;
  logic w_restart;

  assign w_accept    = data_in_valid & ~r_holding_full;
  assign w_last_stop = (r_state == STOP) & w_tick & (r_stop_cnt == c_STOP_LAST);
  // Accepts that can start a frame immediately bypass the holding register.
  assign w_direct    = w_accept & ((r_state == IDLE) | w_last_stop);
  // Only a start from IDLE needs the timer realigned; the STOP->START path
  // already lands on a wrap.
  assign w_restart   = (r_state == IDLE) & (w_accept | r_holding_full);

`ifdef UART_TRANSMITTER_PARITY_EN
  logic w_parity;
  assign w_parity = ^r_shift;
`endif

  assign data_in_ready = ~r_holding_full;
  assign uart_tx       = r_tx;
  assign busy          = r_busy;

  uart_bit_timer #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_bit_timer (
    .clock  (clock),
    .clear  (clear),
    .restart(w_restart),
    .tick   (w_tick)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state        <= IDLE;
      r_shift        <= '0;
      r_holding      <= '0;
      r_holding_full <= 1'b0;
      r_index        <= '0;
      r_stop_cnt     <= '0;
      r_tx           <= 1'b1;
      r_busy         <= 1'b0;
    end else begin
      if (w_accept && !w_direct) begin
        r_holding      <= data_in;
        r_holding_full <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (r_holding_full) begin
            r_shift        <= r_holding;
            r_holding_full <= 1'b0;
            r_state        <= START;
            r_tx           <= 1'b0;
            r_busy         <= 1'b1;
          end else if (w_accept) begin
            r_shift <= data_in;
            r_state <= START;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
          end
        end

        START: begin
          if (w_tick) begin
            r_state <= DATA;
            r_index <= '0;
            r_tx    <= r_shift[0];
          end
        end

        DATA: begin
          if (w_tick) begin
            if (r_index == 3'd7) begin
`ifdef UART_TRANSMITTER_PARITY_EN
              r_state <= PARITY;
              r_tx    <= w_parity;
`else
              r_state    <= STOP;
              r_stop_cnt <= '0;
              r_tx       <= 1'b1;
`endif
            end else begin
              r_index <= r_index + 3'd1;
              r_tx    <= r_shift[r_index + 3'd1];
            end
          end
        end

`ifdef UART_TRANSMITTER_PARITY_EN
        PARITY: begin
          if (w_tick) begin
            r_state    <= STOP;
            r_stop_cnt <= '0;
            r_tx       <= 1'b1;
          end
        end
`endif

        STOP: begin
          if (w_last_stop) begin
            if (r_holding_full) begin
              r_shift        <= r_holding;
              r_holding_full <= 1'b0;
              r_state        <= START;
              r_tx           <= 1'b0;
            end else if (w_accept) begin
              r_shift <= data_in;
              r_state <= START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= IDLE;
              r_tx    <= 1'b1;
              r_busy  <= 1'b0;
            end
          end else if (w_tick) begin
            r_stop_cnt <= r_stop_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule : uart_transmitter
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_transmitter
//  Description : Directed self-checking bench for uart_transmitter. Drives a
//                4-clock-per-bit instance for reset, single byte, parity,
//                back-to-back and clear-mid-frame cases, and an 18-clock
//                instance for a full-length 0xFF frame. Expected line values
//                come from a frame bit model honouring
//                UART_TRANSMITTER_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_transmitter;

`ifdef UART_TRANSMITTER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NBITS = 1 + 8 + PAR + 2;
  localparam int N4    = NBITS * 4;
  localparam int N18   = NBITS * 18;

  logic       clock = 1'b0;
  logic       clear;
  logic       v4, v18;
  logic [7:0] d4, d18;
  logic       ready4, tx4, busy4;
  logic       ready18, tx18, busy18;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  uart_transmitter #(.CLOCKS_PER_BIT(4), .STOP_BITS(2)) dut (
    .clock        (clock),
    .clear        (clear),
    .data_in_valid(v4),
    .data_in      (d4),
    .data_in_ready(ready4),
    .uart_tx      (tx4),
    .busy         (busy4)
  );

  uart_transmitter #(.CLOCKS_PER_BIT(18), .STOP_BITS(2)) dut18 (
    .clock        (clock),
    .clear        (clear),
    .data_in_valid(v18),
    .data_in      (d18),
    .data_in_ready(ready18),
    .uart_tx      (tx18),
    .busy         (busy18)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line level for bit slot k of a frame carrying byte b.
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (PAR == 1 && k == 9) return ^b;
    return 1'b1;
  endfunction

  // Called at the negedge of frame cycle 'first'; checks cycles first..last-1.
  task automatic expect_frame(input string tag, input logic [7:0] b, input bit big,
                              input int first, input int last);
    int cpb;
    cpb = big ? 18 : 4;
    for (int i = first; i < last; i++) begin
      chk($sformatf("%s_tx_c%0d", tag, i), big ? {7'd0, tx18} : {7'd0, tx4},
          {7'd0, exp_bit(b, i / cpb)});
      chk($sformatf("%s_busy_c%0d", tag, i), big ? {7'd0, busy18} : {7'd0, busy4}, 8'd1);
      @(negedge clock);
    end
  endtask

  initial begin
    clear = 1'b1;
    v4 = 1'b0; d4 = 8'h00; v18 = 1'b0; d18 = 8'h00;

    // Reset held for three cycles
    repeat (3) begin
      @(negedge clock);
      chk("rst_tx", {7'd0, tx4}, 8'd1);
      chk("rst_ready", {7'd0, ready4}, 8'd1);
      chk("rst_busy", {7'd0, busy4}, 8'd0);
      chk("rst_tx18", {7'd0, tx18}, 8'd1);
    end
    clear = 1'b0;
    @(negedge clock);

    // Single byte 0xA5 from IDLE
    v4 = 1'b1; d4 = 8'hA5;
    @(negedge clock);
    v4 = 1'b0;
    chk("a5_ready", {7'd0, ready4}, 8'd1);
    expect_frame("a5", 8'hA5, 1'b0, 0, N4);
    chk("a5_end_busy", {7'd0, busy4}, 8'd0);
    chk("a5_end_tx", {7'd0, tx4}, 8'd1);

    // Parity of 0x07
    v4 = 1'b1; d4 = 8'h07;
    @(negedge clock);
    v4 = 1'b0;
    expect_frame("p07", 8'h07, 1'b0, 0, N4);
    chk("p07_end_busy", {7'd0, busy4}, 8'd0);

    // Back-to-back 0x01 then 0x80
    v4 = 1'b1; d4 = 8'h01;
    @(negedge clock);
    chk("b2b_start_tx", {7'd0, tx4}, 8'd0);
    v4 = 1'b1; d4 = 8'h80;
    @(negedge clock);
    v4 = 1'b0;
    chk("b2b_ready_low", {7'd0, ready4}, 8'd0);
    expect_frame("b2b01", 8'h01, 1'b0, 1, N4 - 1);
    chk("b2b_ready_held", {7'd0, ready4}, 8'd0);
    expect_frame("b2b01", 8'h01, 1'b0, N4 - 1, N4);
    chk("b2b_ready_back", {7'd0, ready4}, 8'd1);
    expect_frame("b2b80", 8'h80, 1'b0, 0, N4);
    chk("b2b_end_busy", {7'd0, busy4}, 8'd0);
    chk("b2b_end_ready", {7'd0, ready4}, 8'd1);

    // Clear at cycle 20 of a 0x3C frame with 0x99 held
    v4 = 1'b1; d4 = 8'h3C;
    @(negedge clock);
    chk("clr_start_tx", {7'd0, tx4}, 8'd0);
    v4 = 1'b1; d4 = 8'h99;
    @(negedge clock);
    v4 = 1'b0;
    chk("clr_held_ready", {7'd0, ready4}, 8'd0);
    expect_frame("c3c", 8'h3C, 1'b0, 1, 20);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    chk("clr_tx", {7'd0, tx4}, 8'd1);
    chk("clr_busy", {7'd0, busy4}, 8'd0);
    chk("clr_ready", {7'd0, ready4}, 8'd1);
    repeat (12) begin
      @(negedge clock);
      chk("clr_idle_tx", {7'd0, tx4}, 8'd1);
      chk("clr_idle_busy", {7'd0, busy4}, 8'd0);
    end
    v4 = 1'b1; d4 = 8'h55;
    @(negedge clock);
    v4 = 1'b0;
    expect_frame("c55", 8'h55, 1'b0, 0, N4);
    chk("c55_end_busy", {7'd0, busy4}, 8'd0);

    // 18-clock instance, 0xFF
    v18 = 1'b1; d18 = 8'hFF;
    @(negedge clock);
    v18 = 1'b0;
    expect_frame("ff18", 8'hFF, 1'b1, 0, N18);
    chk("ff18_end_busy", {7'd0, busy18}, 8'd0);
    chk("ff18_end_tx", {7'd0, tx18}, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_uart_transmitter
`default_nettype wire
